// File: rtl/adc_spi_if.sv
// adc_spi_if: host handshake, result bus and ADC serial pins of the SPI ADC controller
`timescale 1ns/1ps
interface adc_spi_if;
  logic start;
  logic [2:0] channel;
  logic busy;
  logic done;
  logic [11:0] data_out;
  logic [2:0] data_channel;
  logic frame_err;
  logic adc_cs_n;
  logic adc_sck;
  logic adc_din;
  logic adc_dout;
  modport slave (
    input  start, channel, adc_dout,
    output busy, done, data_out, data_channel, frame_err, adc_cs_n, adc_sck, adc_din
  );
  modport master (
    output start, channel, adc_dout,
    input  busy, done, data_out, data_channel, frame_err, adc_cs_n, adc_sck, adc_din
  );
endinterface

// File: rtl/adc_spi_controller.sv
// adc_spi_controller: 16-bit SPI frame to a multiplexed ADC, 3.125 MHz sck from 50 MHz
`timescale 1ns/1ps
module adc_spi_controller (
  input logic clk_50M,
  input logic rst_n,
  adc_spi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;
  state_t state, next_state;
  logic [3:0] phase, bit_cnt;
  logic [2:0] ch_lat, prev_ch;
  logic [15:0] shift;
  logic [15:0] cmd;
  logic last;
  assign cmd = {2'b00, ch_lat, 11'b0};
  assign last = state == SHIFT && phase == 4'd15 && bit_cnt == 4'd15;
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = bus.start ? SETUP : IDLE;
      SETUP: next_state = phase == 4'd7 ? SHIFT : SETUP;
      SHIFT: next_state = last ? QUIET : SHIFT;
      QUIET: next_state = phase == 4'd7 ? IDLE : QUIET;
      default: next_state = IDLE;
    endcase
  end
  // phase restarts on every state change; sck is its MSB while shifting
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      phase <= '0;
      bit_cnt <= '0;
      ch_lat <= '0;
      prev_ch <= '0;
      shift <= '0;
      bus.data_out <= '0;
      bus.data_channel <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      phase <= (next_state != state || state == IDLE) ? 4'd0 : phase + 4'd1;
      if (state == SHIFT && phase == 4'd15) bit_cnt <= bit_cnt + 4'd1;
      if (state == IDLE && bus.start) ch_lat <= bus.channel;
      if (state == SHIFT && phase == 4'd7) shift <= {shift[14:0], bus.adc_dout};
      // the ADC returns the channel addressed in the previous frame
      if (last) begin
        bus.data_out <= shift[11:0];
        bus.frame_err <= |shift[15:12];
        bus.data_channel <= prev_ch;
        prev_ch <= ch_lat;
      end
    end
  always_comb begin
    bus.busy = state != IDLE;
    bus.adc_cs_n = !(state == SETUP || state == SHIFT);
    bus.adc_sck = state != SHIFT || phase[3];
    bus.adc_din = state == SHIFT && cmd[~bit_cnt];
    bus.done = state == QUIET && phase == 4'd0;
  end
endmodule

// File: tb/tb_adc_spi_controller.sv
// tb_adc_spi_controller: directed frames with an ADC model and a result scoreboard
`timescale 1ns/1ps
module tb_adc_spi_controller;
  logic clk_50M = 1'b0;
  logic rst_n = 1'b0;
  adc_spi_if bus();
  adc_spi_controller dut (.clk_50M(clk_50M), .rst_n(rst_n), .bus(bus));
  always #10 clk_50M = ~clk_50M;
  typedef struct packed {logic [11:0] d; logic [2:0] ch; logic fe;} exp_t;
  exp_t q[$];
  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int bit_i = 0;
  logic [15:0] adc_word = '0;
  logic [2:0] prev_m = '0;
  always @(posedge clk_50M) cyc <= cyc + 1;
  // ADC model: presents the next bit MSB first on every sck falling edge
  always @(negedge bus.adc_sck or posedge bus.adc_cs_n)
    if (bus.adc_cs_n) bit_i = 0;
    else if (bit_i < 16) begin
      bus.adc_dout = adc_word[15 - bit_i];
      bit_i++;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic frame(input logic [2:0] ch, input logic [15:0] word, input int pulse_at,
                       input int abort_at, output int t_start, output int t_done);
    int falls, last_fall, period, cs_low, sck_low, dones, done_i;
    logic last_sck;
    logic [15:0] cmd_seen, cmd_exp;
    exp_t e;
    falls = 0; last_fall = 0; period = 0; cs_low = 0; sck_low = 0; dones = 0; done_i = 0;
    last_sck = 1'b1; cmd_seen = '0; cmd_exp = {2'b00, ch, 11'b0}; t_done = 0;
    adc_word = word;
    q.push_back(exp_t'{word[11:0], prev_m, |word[15:12]});
    prev_m = ch;
    bus.start = 1'b1;
    bus.channel = ch;
    t_start = cyc;
    for (int i = 1; i <= 273; i++) begin
      @(negedge clk_50M);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.channel = ~ch;
        chk("cs_n_fall", bus.adc_cs_n, 0);
        chk("busy_set", bus.busy, 1);
      end
      if (i == pulse_at) begin
        bus.start = 1'b1;
        bus.channel = 3'd7;
      end
      if (i == pulse_at + 1) bus.start = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cs_n", bus.adc_cs_n, 1);
        chk("rst_sck", bus.adc_sck, 1);
        chk("rst_busy", bus.busy, 0);
        void'(q.pop_back());
        prev_m = '0;
        return;
      end
      if (!bus.adc_cs_n) cs_low++;
      if (!bus.adc_sck) sck_low++;
      if (last_sck && !bus.adc_sck) begin
        falls++;
        cmd_seen = {cmd_seen[14:0], bus.adc_din};
        if (falls == 2) period = i - last_fall;
        last_fall = i;
      end
      last_sck = bus.adc_sck;
      if (bus.done) begin
        dones++;
        done_i = i;
        t_done = cyc;
        chk("sb_size", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("data_out", bus.data_out, e.d);
          chk("data_channel", bus.data_channel, e.ch);
          chk("frame_err", bus.frame_err, e.fe);
        end
      end
      if (i == 272) chk("busy_quiet", bus.busy, 1);
      if (i == 273) chk("busy_clear", bus.busy, 0);
    end
    chk("sck_falls", falls, 16);
    chk("din_cmd", cmd_seen, cmd_exp);
    chk("sck_period_ns", period * 20, 320);
    chk("sck_low_cycles", sck_low, 128);
    chk("cs_low_cycles", cs_low, 264);
    chk("done_count", dones, 1);
    chk("done_cycle", done_i, 265);
  endtask
  initial begin
    int ts, td, ts1, td2, dones;
    bus.start = 1'b0;
    bus.channel = '0;
    repeat (3) @(negedge clk_50M);
    chk("rst_cs_n0", bus.adc_cs_n, 1);
    chk("rst_sck0", bus.adc_sck, 1);
    chk("rst_din0", bus.adc_din, 0);
    chk("rst_busy0", bus.busy, 0);
    chk("rst_done0", bus.done, 0);
    chk("rst_data0", bus.data_out, 0);
    chk("rst_chan0", bus.data_channel, 0);
    chk("rst_ferr0", bus.frame_err, 0);
    rst_n = 1'b1;
    frame(3'd3, 16'h0ABC, 0, 0, ts, td);
    frame(3'd5, 16'h0456, 0, 0, ts1, td);
    frame(3'd2, 16'h0789, 0, 0, ts, td2);
    chk("pipe_total", td2 - ts1, 538);
    frame(3'd1, 16'h8123, 0, 0, ts, td);
    frame(3'd4, 16'h0FED, 50, 0, ts, td);
    frame(3'd6, 16'h0AAA, 0, 100, ts, td);
    dones = 0;
    repeat (5) begin
      @(negedge clk_50M);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_data", bus.data_out, 0);
    chk("abort_chan", bus.data_channel, 0);
    rst_n = 1'b1;
    frame(3'd2, 16'h0555, 0, 0, ts, td);
    frame(3'd0, 16'hF001, 0, 0, ts, td);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_spi_controller.md
ADC_SPI_CONTROLLER -- requirements
Module: adc_spi_controller

Interface
REQ-001 SHALL have port clk_50M  input  1  50 MHz system clock; all sequential logic on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-004 SHALL have port channel  input  3  ADC channel address for the next conversion.
REQ-005 SHALL have port busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-006 SHALL have port done  output  1  single-cycle pulse when data_out is valid.
REQ-007 SHALL have port data_out  output  12  last converted sample, held until the next done.
REQ-008 SHALL have port data_channel  output  3  channel to which data_out belongs.
REQ-009 SHALL have port frame_err  output  1  set with done when the leading nibble of the frame was non-zero.
REQ-010 SHALL have port adc_cs_n  output  1  ADC chip select, active low.
REQ-011 SHALL have port adc_sck  output  1  ADC serial clock, 3.125 MHz, idle high.
REQ-012 SHALL have port adc_din  output  1  command bit to the ADC.
REQ-013 SHALL have port adc_dout  input  1  data bit from the ADC.

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, QUIET.
REQ-015 SHALL, in IDLE: adc_cs_n=1, adc_sck=1, adc_din=0, busy=0.
REQ-016 SHALL accept start=1 in IDLE at cycle T, latch channel, and enter SETUP with adc_cs_n=0 and busy=1 from T+1.
REQ-017 SHALL ignore start and channel changes in every state other than IDLE.
REQ-018 SHALL hold SETUP for 8 cycles (T+1..T+8) with adc_sck=1.
REQ-019 SHALL, in SHIFT (T+9..T+264), generate 16 adc_sck periods of 16 cycles each: 8 cycles low, then 8 cycles high.
REQ-020 SHALL update adc_din on the cycle adc_sck goes low for bit k (k=0..15) with bit 15-k of command word {2'b00, latched channel, 11'b0}.
REQ-021 SHALL sample adc_dout into a 16-bit shift register (MSB first) at the clock edge that drives adc_sck from 0 to 1.
REQ-022 SHALL use a 4-bit phase counter and a 4-bit bit counter; both wrap 15->0, and the bit-counter wrap after bit 15 ends SHIFT.
REQ-023 SHALL, at T+265: enter QUIET, set adc_cs_n=1 and adc_sck=1, pulse done=1 for exactly one cycle, and load data_out=shift[11:0] and frame_err=(shift[15:12]!=0).
REQ-024 SHALL, at T+265, load data_channel with the address sent in the previous frame (the ADC converts the previously addressed channel), then record the current latched channel as the previous address.
REQ-025 SHALL hold QUIET for 8 cycles (T+265..T+272) with busy=1, then enter IDLE with busy=0 at T+273.
REQ-026 SHALL accept a start asserted at T+273; back-to-back frames SHALL have period 273 cycles.
REQ-027 SHALL hold data_out, data_channel and frame_err stable between done pulses.

Reset
REQ-028 SHALL, on rst_n=0 in any state, immediately force IDLE: adc_cs_n=1, adc_sck=1, adc_din=0, busy=0, done=0, data_out=0, data_channel=0, frame_err=0, previous address=0, counters=0.
REQ-029 SHALL abort a frame in progress on reset; no done is produced for it, and a start is accepted from the first rising clk_50M edge after rst_n deasserts.

Verification
REQ-030 Single frame: reset, then start with channel=3, ADC model returns 0x0ABC -> adc_cs_n falls at T+1; 16 sck falling edges with adc_din high only at bits 2..4 (011); done at T+265; data_out=0xABC; data_channel=0; frame_err=0.
REQ-031 Pipelined channel: frames with channel 5 then 2 -> second done reports data_channel=5; total cycles from first start to second done = 273+265.
REQ-032 Framing error: ADC model drives leading nibble 4'b1000 with data 0x123 -> done with data_out=0x123 and frame_err=1.
REQ-033 Busy protection: start pulsed at T+50 with channel=7 -> ignored; adc_din pattern and latched channel unchanged; a single done only.
REQ-034 Reset mid-frame: rst_n low at T+100 -> adc_cs_n=1 and adc_sck=1 within the same cycle; no done; data_out remains 0; the next frame reports data_channel=0.
REQ-035 Clock check: measured adc_sck period in SHIFT = 320 ns, duty 50%; adc_cs_n low duration = 264 cycles.
